// File: rtl/risc16_pkg.sv
// rtl/risc16_pkg.sv - risc16 instruction word layout shared by the encoder and decoder
package risc16_pkg;

    localparam int INST_W       = 16;
    localparam int ALUOP_W      = 5;
    localparam int OPC_W        = 4;
    localparam int REG_W        = 4;
    localparam int IMME_W       = 16;
    localparam int IMM_FORM_BIT = 0;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int RA_HI  = 7;
    localparam int RA_LO  = 4;
    localparam int RB_HI  = 3;
    localparam int RB_LO  = 0;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    // Immediate bits above IMM_HI cannot be carried by the word
    localparam int IMME_TOP_LO = IMM_HI + 1;

    function automatic logic [INST_W-1:0] encode_inst(
        input logic [ALUOP_W-1:0] aluop,
        input logic [REG_W-1:0]   seld,
        input logic [REG_W-1:0]   sela,
        input logic [REG_W-1:0]   selb,
        input logic [IMME_W-1:0]  imme
    );
        logic [INST_W-1:0] w;
        w = '0;
        w[OP_HI:OP_LO] = aluop[ALUOP_W-1:1];
        w[RD_HI:RD_LO] = seld;
        if (aluop[IMM_FORM_BIT]) begin
            w[IMM_HI:IMM_LO] = imme[IMM_HI:IMM_LO];
        end else begin
            w[RA_HI:RA_LO] = sela;
            w[RB_HI:RB_LO] = selb;
        end
        return w;
    endfunction

endpackage

// File: rtl/inst_enco_if.sv
// rtl/inst_enco_if.sv - field-set input and instruction stream output of the encoder
interface inst_enco_if #(
    parameter int AW = 2
);
    logic        I_EN;
    logic        I_VALID;
    logic        O_READY;
    logic [4:0]  I_ALUOP;
    logic [3:0]  I_SELD;
    logic [3:0]  I_SELA;
    logic [3:0]  I_SELB;
    logic [15:0] I_IMME;
    logic        O_VALID;
    logic        I_READY;
    logic [15:0] O_INST;
    logic [AW:0] O_COUNT;
    logic        O_ERR;

    modport slave (
        input  I_EN, I_VALID, I_ALUOP, I_SELD, I_SELA, I_SELB, I_IMME, I_READY,
        output O_READY, O_VALID, O_INST, O_COUNT, O_ERR
    );

    modport master (
        output I_EN, I_VALID, I_ALUOP, I_SELD, I_SELA, I_SELB, I_IMME, I_READY,
        input  O_READY, O_VALID, O_INST, O_COUNT, O_ERR
    );
endinterface

// File: rtl/inst_enco_fifo.sv
// rtl/inst_enco_fifo.sv - DEPTH x 16 word queue with occupancy count
module inst_enco_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [15:0]   wdata,
    input  logic          pop,
    output logic [15:0]   rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage is not cleared; stale entries are unreachable once the pointers reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/inst_enco.sv
// rtl/inst_enco.sv - packs ALU op/register/immediate fields into queued 16-bit words
// Optional immediate range checker enabled by INST_ENCO_RANGE_CHECK_EN.
module inst_enco
    import risc16_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        I_CLK,
    input  logic        I_RST_N,
    inst_enco_if.slave  bus
);
    logic              out_of_reset;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [INST_W-1:0] wdata;
    logic [INST_W-1:0] rdata;

    // Holds O_READY low for the cycle in which reset is sampled released
    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) begin
            out_of_reset <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
        end
    end

    assign wdata = encode_inst(bus.I_ALUOP, bus.I_SELD, bus.I_SELA, bus.I_SELB, bus.I_IMME);

    assign bus.O_READY = !full && out_of_reset;
    assign bus.O_VALID = !empty && bus.I_EN;
    assign bus.O_INST  = bus.O_VALID ? rdata : '0;
    assign push        = bus.I_VALID && bus.O_READY;
    assign pop         = bus.O_VALID && bus.I_READY;

    inst_enco_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (I_CLK),
        .rst_n (I_RST_N),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .count (bus.O_COUNT),
        .full  (full),
        .empty (empty)
    );

`ifdef INST_ENCO_RANGE_CHECK_EN
    logic err;

    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) begin
            err <= 1'b0;
        end else if (push && bus.I_ALUOP[IMM_FORM_BIT] && (|bus.I_IMME[IMME_W-1:IMME_TOP_LO])) begin
            err <= 1'b1;
        end
    end

    assign bus.O_ERR = err;
`else
    logic unused_imme_top;

    assign unused_imme_top = ^bus.I_IMME[IMME_W-1:IMME_TOP_LO];
    assign bus.O_ERR       = 1'b0;
`endif
endmodule

// File: tb/tb_inst_enco.sv
// tb/tb_inst_enco.sv - queue-model and directed-vector bench for inst_enco
module tb_inst_enco;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
`ifdef INST_ENCO_RANGE_CHECK_EN
    localparam bit RANGE_ON = 1'b1;
`else
    localparam bit RANGE_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inst_enco_if #(.AW(AW)) bus ();

    inst_enco #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .I_CLK   (clk),
        .I_RST_N (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [3:0] d,
                                        input logic [3:0] a, input logic [3:0] b,
                                        input logic [15:0] imm);
        return {op[4:1], d, (op[0] ? imm[7:0] : {a, b})};
    endfunction

    // Reference: a plain queue of expected words plus the ready-after-reset flag
    logic [15:0] mq[$];
    bit          m_up    = 1'b0;
    bit          m_err   = 1'b0;
    bit          started = 1'b0;
    bit          m_acc;
    bit          m_rel;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_up  = 1'b0;
            m_err = 1'b0;
        end else begin
            m_acc = bus.I_VALID && m_up && (mq.size() < DEPTH);
            m_rel = (mq.size() > 0) && bus.I_EN && bus.I_READY;
            if (m_rel) void'(mq.pop_front());
            if (m_acc) begin
                mq.push_back(enc(bus.I_ALUOP, bus.I_SELD, bus.I_SELA, bus.I_SELB, bus.I_IMME));
                if (RANGE_ON && bus.I_ALUOP[0] && (bus.I_IMME[15:8] != 8'h00)) m_err = 1'b1;
            end
            m_up = 1'b1;
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("o_ready", bus.O_READY, m_up && (mq.size() < DEPTH));
            chk("o_valid", bus.O_VALID, (mq.size() > 0) && bus.I_EN);
            chk("o_inst", bus.O_INST, ((mq.size() > 0) && bus.I_EN) ? mq[0] : 16'h0000);
            chk("o_count", bus.O_COUNT, mq.size());
            chk("o_err", bus.O_ERR, m_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [4:0] op, input logic [3:0] d, input logic [3:0] a,
                              input logic [3:0] b, input logic [15:0] imm);
        bus.I_ALUOP = op;
        bus.I_SELD  = d;
        bus.I_SELA  = a;
        bus.I_SELB  = b;
        bus.I_IMME  = imm;
    endtask

    task automatic push_one(input logic [4:0] op, input logic [3:0] d, input logic [3:0] a,
                            input logic [3:0] b, input logic [15:0] imm);
        set_fields(op, d, a, b, imm);
        bus.I_VALID = 1'b1;
        step();
        bus.I_VALID = 1'b0;
    endtask

    initial begin
        bus.I_EN    = 1'b1;
        bus.I_VALID = 1'b1;
        bus.I_READY = 1'b0;
        set_fields(5'h0, 4'h0, 4'h0, 4'h0, 16'h0);
        rst_n = 1'b0;

        // Reset held two clocks with I_VALID=1
        step();
        step();
        @(negedge clk);
        chk("rst_ready", bus.O_READY, 1'b0);
        chk("rst_count", bus.O_COUNT, 0);
        chk("rst_inst", bus.O_INST, 16'h0000);
        rst_n       = 1'b1;
        bus.I_VALID = 1'b0;
        step();
        @(negedge clk);
        chk("ready_after_rst", bus.O_READY, 1'b1);

        // Reg form
        push_one(5'b11000, 4'd7, 4'd0, 4'd7, 16'h0000);
        @(negedge clk);
        chk("reg_valid", bus.O_VALID, 1'b1);
        chk("reg_inst", bus.O_INST, 16'b1100011100000111);
        bus.I_READY = 1'b1;
        step();
        bus.I_READY = 1'b0;

        // Imm form
        push_one(5'b00011, 4'd8, 4'd0, 4'd0, 16'h0091);
        @(negedge clk);
        chk("imm_inst", bus.O_INST, 16'b0001100010010001);
        chk("imm_err", bus.O_ERR, 1'b0);
        bus.I_READY = 1'b1;
        step();
        bus.I_READY = 1'b0;

        // Fill with five offered words; fifth is refused
        for (int i = 0; i < 5; i++) begin
            set_fields(5'(i * 6 + 1), 4'(i), 4'(i + 1), 4'(i + 2), 16'(i * 16 + 3));
            bus.I_VALID = 1'b1;
            step();
        end
        @(negedge clk);
        chk("full_count", bus.O_COUNT, 4);
        chk("full_ready", bus.O_READY, 1'b0);
        // Full + push + pop: only the pop happens
        bus.I_READY = 1'b1;
        step();
        bus.I_VALID = 1'b0;
        @(negedge clk);
        chk("full_push_pop_count", bus.O_COUNT, 3);
        for (int i = 0; i < 4; i++) step();
        @(negedge clk);
        chk("drained_count", bus.O_COUNT, 0);

        // Output stalled by I_EN=0
        bus.I_READY = 1'b0;
        push_one(5'b10100, 4'd3, 4'd5, 4'd9, 16'h0);
        push_one(5'b01101, 4'd2, 4'd0, 4'd0, 16'h00a5);
        bus.I_EN    = 1'b0;
        bus.I_READY = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("stall_valid", bus.O_VALID, 1'b0);
        chk("stall_count", bus.O_COUNT, 2);
        push_one(5'b00110, 4'd15, 4'd14, 4'd13, 16'h0);
        @(negedge clk);
        chk("stall_push_count", bus.O_COUNT, 3);
        bus.I_EN = 1'b1;
        for (int i = 0; i < 3; i++) step();
        @(negedge clk);
        chk("stall_drained", bus.O_COUNT, 0);

        // Immediate out of range
        bus.I_READY = 1'b0;
        push_one(5'b00011, 4'd8, 4'd0, 4'd0, 16'h0191);
        @(negedge clk);
        chk("range_inst_lo", bus.O_INST[7:0], 8'h91);
        chk("range_err", bus.O_ERR, RANGE_ON);
        push_one(5'b11110, 4'd1, 4'd2, 4'd3, 16'h0);
        bus.I_READY = 1'b1;
        for (int i = 0; i < 3; i++) step();
        @(negedge clk);
        chk("range_err_held", bus.O_ERR, RANGE_ON);

        // Reset with data mid-stream
        bus.I_READY = 1'b0;
        push_one(5'b10010, 4'd4, 4'd4, 4'd4, 16'h0);
        push_one(5'b10011, 4'd6, 4'd0, 4'd0, 16'hff00);
        rst_n = 1'b0;
        step();
        @(negedge clk);
        chk("midrst_count", bus.O_COUNT, 0);
        chk("midrst_valid", bus.O_VALID, 1'b0);
        chk("midrst_err", bus.O_ERR, 1'b0);
        rst_n = 1'b1;
        step();

        // Mixed traffic across several pointer wraps
        for (int i = 0; i < 60; i++) begin
            set_fields(5'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom));
            bus.I_VALID = 1'($urandom_range(0, 1));
            bus.I_READY = 1'($urandom_range(0, 2) != 0);
            bus.I_EN    = 1'($urandom_range(0, 4) != 0);
            step();
        end
        bus.I_VALID = 1'b0;
        bus.I_READY = 1'b1;
        bus.I_EN    = 1'b1;
        for (int i = 0; i < 6; i++) step();
        @(negedge clk);
        chk("final_count", bus.O_COUNT, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
